// File: rtl/tick_sched_pkg.sv
// Shared types and parameter defaults for the tick scheduler.
// Consumers size their channel index and period fields from here.
package tick_sched_pkg;

    localparam int DEF_PRESCALE_W = 11;
    localparam int DEF_NUM_CH     = 4;
    localparam int DEF_PERIOD_W   = 8;

    typedef logic [$clog2(DEF_NUM_CH)-1:0] ch_idx_t;
    typedef logic [DEF_PERIOD_W-1:0]       period_t;

    typedef struct packed {
        logic    en;
        period_t period;
    } ch_cfg_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first request at or after ptr,
// wrapping modulo N.
module rr_arbiter #(
    parameter int N = 4
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] ptr,
    output logic [N-1:0]         gnt,
    output logic [$clog2(N)-1:0] gnt_idx,
    output logic                 gnt_valid
);

    localparam int IW = $clog2(N);

    int idx;

    always_comb begin
        gnt       = '0;
        gnt_idx   = '0;
        gnt_valid = 1'b0;
        idx       = 0;
        for (int i = 0; i < N; i++) begin
            idx = (int'(ptr) + i) % N;
            if (!gnt_valid && req[idx]) begin
                gnt_valid = 1'b1;
                gnt_idx   = IW'(idx);
                gnt[idx]  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/tick_scheduler.sv
// Shared base-tick prescaler with per-channel period counters and a
// round-robin arbiter issuing at most one service strobe per clock.
module tick_scheduler
    import tick_sched_pkg::*;
#(
    parameter int PRESCALE_W = DEF_PRESCALE_W,
    parameter int NUM_CH     = DEF_NUM_CH,
    parameter int PERIOD_W   = DEF_PERIOD_W
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      cfg_we,
    input  logic [$clog2(NUM_CH)-1:0] cfg_ch,
    input  logic [PERIOD_W-1:0]       cfg_period,
    input  logic                      cfg_en,
    input  logic                      clr_overrun,
    output logic                      base_tick,
    output logic [NUM_CH-1:0]         ch_strobe,
    output logic [NUM_CH-1:0]         pending,
    output logic [NUM_CH-1:0]         overrun
);

    localparam int IW = $clog2(NUM_CH);

    typedef struct packed {
        logic                en;
        logic [PERIOD_W-1:0] period;
    } cfg_t;

    logic [PRESCALE_W-1:0] presc;
    cfg_t                  cfg   [NUM_CH];
    logic [PERIOD_W-1:0]   count [NUM_CH];
    logic [IW-1:0]         ptr;

    logic [NUM_CH-1:0] gnt;
    logic [IW-1:0]     gnt_idx;
    logic              gnt_valid;
    logic [NUM_CH-1:0] active;
    logic [NUM_CH-1:0] wr_sel;
    logic [NUM_CH-1:0] due;
    logic [NUM_CH-1:0] pending_d;
    logic [NUM_CH-1:0] overrun_d;

    rr_arbiter #(.N(NUM_CH)) u_arb (
        .req       (pending),
        .ptr       (ptr),
        .gnt       (gnt),
        .gnt_idx   (gnt_idx),
        .gnt_valid (gnt_valid)
    );

    // A write to a channel masks its due event for that cycle.
    always_comb begin
        for (int n = 0; n < NUM_CH; n++) begin
            active[n] = cfg[n].en && (cfg[n].period != '0);
            wr_sel[n] = cfg_we && (int'(cfg_ch) == n);
            due[n]    = base_tick && active[n] && !wr_sel[n]
                        && (count[n] <= PERIOD_W'(1));
        end
    end

    always_comb begin
        pending_d = pending & ~gnt;
        overrun_d = clr_overrun ? '0 : overrun;
        for (int n = 0; n < NUM_CH; n++) begin
            if (due[n]) begin
                if (pending[n] && !gnt[n])
                    overrun_d[n] = 1'b1;
                pending_d[n] = 1'b1;
            end
        end
        pending_d = pending_d & ~wr_sel;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            presc     <= '0;
            base_tick <= 1'b0;
            ptr       <= '0;
            ch_strobe <= '0;
            pending   <= '0;
            overrun   <= '0;
            for (int n = 0; n < NUM_CH; n++) begin
                cfg[n]   <= '0;
                count[n] <= '0;
            end
        end else begin
            presc     <= presc + 1'b1;
            base_tick <= (presc == '0);
            ch_strobe <= gnt;
            pending   <= pending_d;
            overrun   <= overrun_d;
            if (gnt_valid)
                ptr <= (int'(gnt_idx) == NUM_CH - 1) ? '0 : gnt_idx + 1'b1;
            for (int n = 0; n < NUM_CH; n++) begin
                if (wr_sel[n]) begin
                    cfg[n].en     <= cfg_en;
                    cfg[n].period <= cfg_period;
                    count[n]      <= cfg_period;
                end else if (due[n]) begin
                    count[n] <= cfg[n].period;
                end else if (base_tick && active[n]) begin
                    count[n] <= count[n] - 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_tick_scheduler.sv
// Directed bench: main, fast-prescaler and three-channel instances
// share clock and reset; each has its own config bus.
module tb_tick_scheduler;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic       we, clr, en;
    logic [1:0] ch;
    logic [7:0] per;
    logic       bt;
    logic [3:0] stb, pend, ovr;

    logic       f_we, f_clr, f_en;
    logic [1:0] f_ch;
    logic [7:0] f_per;
    logic       f_bt;
    logic [3:0] f_stb, f_pend, f_ovr;

    logic       t_we, t_clr, t_en;
    logic [1:0] t_ch;
    logic [7:0] t_per;
    logic       t_bt;
    logic [2:0] t_stb, t_pend, t_ovr;

    int checks = 0;
    int errors = 0;
    int cyc;
    logic [3:0] acc_s, acc_p, acc_ts, acc_tp;

    tick_scheduler #(.PRESCALE_W(4), .NUM_CH(4), .PERIOD_W(8)) dut (
        .clk(clk), .rst(rst), .cfg_we(we), .cfg_ch(ch),
        .cfg_period(per), .cfg_en(en), .clr_overrun(clr),
        .base_tick(bt), .ch_strobe(stb), .pending(pend), .overrun(ovr)
    );

    tick_scheduler #(.PRESCALE_W(1), .NUM_CH(4), .PERIOD_W(8)) dut_fast (
        .clk(clk), .rst(rst), .cfg_we(f_we), .cfg_ch(f_ch),
        .cfg_period(f_per), .cfg_en(f_en), .clr_overrun(f_clr),
        .base_tick(f_bt), .ch_strobe(f_stb), .pending(f_pend),
        .overrun(f_ovr)
    );

    tick_scheduler #(.PRESCALE_W(4), .NUM_CH(3), .PERIOD_W(8)) dut3 (
        .clk(clk), .rst(rst), .cfg_we(t_we), .cfg_ch(t_ch),
        .cfg_period(t_per), .cfg_en(t_en), .clr_overrun(t_clr),
        .base_tick(t_bt), .ch_strobe(t_stb), .pending(t_pend),
        .overrun(t_ovr)
    );

    always @(posedge clk or negedge rst)
        if (!rst) cyc <= 0;
        else      cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [3:0] obs,
                       input logic [3:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic at(input int k);
        while (cyc < k) begin
            @(posedge clk);
            #1;
            acc_s  = acc_s | stb;
            acc_p  = acc_p | pend;
            acc_ts = acc_ts | {1'b0, t_stb};
            acc_tp = acc_tp | {1'b0, t_pend};
        end
    endtask

    task automatic clear_acc();
        acc_s = '0; acc_p = '0; acc_ts = '0; acc_tp = '0;
    endtask

    task automatic wr(input int d, input int k, input int c,
                      input int p, input logic e);
        at(k - 1);
        case (d)
            0: begin we = 1; ch = 2'(c); per = 8'(p); en = e; end
            1: begin f_we = 1; f_ch = 2'(c); f_per = 8'(p); f_en = e; end
            default: begin t_we = 1; t_ch = 2'(c); t_per = 8'(p); t_en = e; end
        endcase
        at(k);
        we = 0; f_we = 0; t_we = 0;
    endtask

    task automatic do_reset();
        rst = 0;
        repeat (3) @(negedge clk);
        rst = 1;
        clear_acc();
    endtask

    initial begin
        we = 0; clr = 0; en = 0; ch = 0; per = 0;
        f_we = 0; f_clr = 0; f_en = 0; f_ch = 0; f_per = 0;
        t_we = 0; t_clr = 0; t_en = 0; t_ch = 0; t_per = 0;
        clear_acc();
        #12;
        chk("rst_bt", {3'b0, bt}, 4'b0);
        chk("rst_stb", stb, 4'b0);
        chk("rst_pend", pend, 4'b0);
        chk("rst_ovr", ovr, 4'b0);
        chk("rst_fbt", {3'b0, f_bt}, 4'b0);
        chk("rst_tbt", {3'b0, t_bt}, 4'b0);

        // prescaler and single channel
        do_reset();
        at(1);  chk("bt_c1", {3'b0, bt}, 4'b1);
        at(2);  chk("bt_c2", {3'b0, bt}, 4'b0);
        chk("idle_stb", stb, 4'b0);
        chk("idle_pend", pend, 4'b0);
        wr(0, 3, 1, 3, 1);
        at(16); chk("bt_c16", {3'b0, bt}, 4'b0);
        at(17); chk("bt_c17", {3'b0, bt}, 4'b1);
        at(33); chk("bt_c33", {3'b0, bt}, 4'b1);
        at(49); chk("s_pend49", pend, 4'b0);
        chk("s_stb49", stb, 4'b0);
        at(50); chk("s_pend50", pend, 4'b0010);
        chk("s_stb50", stb, 4'b0);
        at(51); chk("s_stb51", stb, 4'b0010);
        chk("s_pend51", pend, 4'b0);
        at(52); chk("s_stb52", stb, 4'b0);
        at(98); chk("s_pend98", pend, 4'b0010);
        at(99); chk("s_stb99", stb, 4'b0010);
        chk("s_ovr", ovr, 4'b0);

        // collision and round robin
        do_reset();
        for (int i = 0; i < 4; i++) wr(0, 3 + i, i, 1, 1);
        at(18); chk("rr_pend18", pend, 4'b1111);
        chk("rr_stb18", stb, 4'b0);
        at(19); chk("rr_stb19", stb, 4'b0001);
        at(20); chk("rr_stb20", stb, 4'b0010);
        at(21); chk("rr_stb21", stb, 4'b0100);
        at(22); chk("rr_stb22", stb, 4'b1000);
        chk("rr_pend22", pend, 4'b0);
        at(23); chk("rr_stb23", stb, 4'b0);
        at(34); chk("rr_pend34", pend, 4'b1111);
        at(35); chk("rr_stb35", stb, 4'b0001);
        chk("rr_ovr", ovr, 4'b0);

        // overrun with fast ticks
        do_reset();
        wr(1, 3, 0, 1, 1);
        wr(1, 4, 1, 1, 1);
        chk("ov_pend4", f_pend, 4'b0001);
        wr(1, 5, 2, 1, 1);
        chk("ov_stb5", f_stb, 4'b0001);
        wr(1, 6, 3, 1, 1);
        chk("ov_pend6", f_pend, 4'b0111);
        at(7);  chk("ov_stb7", f_stb, 4'b0010);
        at(8);  chk("ov_stb8", f_stb, 4'b0100);
        chk("ov_ovr8", f_ovr, 4'b0001);
        chk("ov_pend8", f_pend, 4'b1111);
        at(9);  chk("ov_stb9", f_stb, 4'b1000);
        at(10); chk("ov_stb10", f_stb, 4'b0001);
        chk("ov_ovr10", f_ovr, 4'b0111);
        f_clr = 1;
        at(11); chk("ov_clr11", f_ovr, 4'b0);
        chk("ov_stb11", f_stb, 4'b0010);
        at(12); chk("ov_setwin", f_ovr, 4'b1001);
        chk("ov_stb12", f_stb, 4'b0100);
        f_clr = 0;
        for (int k = 13; k < 30; k++) begin
            at(k);
            chk("ov_onehot", {3'b0, $onehot0(f_stb)}, 4'b1);
        end

        // config boundaries
        do_reset();
        wr(0, 3, 0, 1, 1);
        wr(0, 4, 1, 0, 1);
        wr(0, 5, 2, 5, 0);
        wr(2, 6, 3, 1, 1);
        wr(0, 18, 0, 2, 1);
        chk("rw_pend18", pend, 4'b0);
        at(19); chk("rw_stb19", stb, 4'b0);
        at(34); chk("rw_pend34", pend, 4'b0);
        at(50); chk("rw_pend50", pend, 4'b0001);
        at(51); chk("rw_stb51", stb, 4'b0001);
        at(100);
        chk("off_stb", acc_s & 4'b0110, 4'b0);
        chk("off_pend", acc_p & 4'b0110, 4'b0);
        chk("oor_stb", acc_ts, 4'b0);
        chk("oor_pend", acc_tp, 4'b0);
        wr(2, 101, 2, 1, 1);
        at(114); chk("t3_pend", {1'b0, t_pend}, 4'b0100);
        at(115); chk("t3_stb", {1'b0, t_stb}, 4'b0100);
        chk("t3_ovr", {1'b0, t_ovr}, 4'b0);

        // reset mid-operation
        do_reset();
        wr(0, 3, 1, 1, 1);
        wr(0, 4, 3, 1, 1);
        at(18); chk("mr_pend", pend, 4'b1010);
        #1 rst = 0;
        #1;
        chk("mr_stb", stb, 4'b0);
        chk("mr_pend0", pend, 4'b0);
        chk("mr_ovr", ovr, 4'b0);
        chk("mr_bt", {3'b0, bt}, 4'b0);
        repeat (2) @(negedge clk);
        rst = 1;
        clear_acc();
        at(70);
        chk("mr_nostb", acc_s, 4'b0);
        chk("mr_nopend", acc_p, 4'b0);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule

// File: doc/tick_scheduler.md
# tick_scheduler

Shares one free-running base tick among NUM_CH requesters. Each requester gets a programmable strobe period, counted in base ticks. It sits between the keypad debouncer, display refresh and lockout timers of the digital-lock design and replaces per-consumer tick generators. The block holds the prescaler, one down-counter per channel, and a round-robin arbiter. The arbiter guarantees at most one channel strobe per clock.

## Interface
- PRESCALE_W, 11: prescaler width; base tick period is 2^PRESCALE_W clocks.
- NUM_CH, 4: number of channels, minimum 2.
- PERIOD_W, 8: width of the per-channel period in base ticks.
- clk  input  1  system clock.
- rst  input  1  asynchronous, active-low reset.
- cfg_we  input  1  one-cycle configuration write strobe.
- cfg_ch  input  $clog2(NUM_CH)  channel index for the write; out-of-range index ignores the write.
- cfg_period  input  PERIOD_W  strobe period in base ticks; 0 means disabled.
- cfg_en  input  1  channel enable.
- clr_overrun  input  1  clears all overrun bits.
- base_tick  output  1  one-clock pulse every 2^PRESCALE_W clocks.
- ch_strobe  output  NUM_CH  one-hot or zero; one-clock service strobe.
- pending  output  NUM_CH  channel is due and has not yet been strobed.
- overrun  output  NUM_CH  sticky; channel became due while already pending.

## Operation
**Reset (rst low):**
- Prescaler = 0, base_tick = 0.
- All channels disabled, period = 0, count = 0.
- pending = 0, overrun = 0, ch_strobe = 0.
- Round-robin pointer = channel 0.

**Prescaler:**
- PRESCALE_W-bit counter increments every clock and wraps.
- base_tick is registered: it is high in the cycle after the counter reads 0.

**Channel n is active when** enabled and period != 0. On base_tick, an active channel acts as follows:
- count > 1: decrement.
- count <= 1: the channel is due. Reload count = period and set pending[n].
- An inactive channel holds its count and never becomes due.

**Config write (cfg_we) to channel n:**
- Load period and enable, set count = cfg_period, clear pending[n].
- The write takes priority over a same-cycle due event on channel n. Other channels are unaffected.

**Arbiter:**
- Each clock, among the pending bits, grant the first set bit at or after the pointer, wrapping modulo NUM_CH.
- ch_strobe <= one-hot grant, registered.
- pending[grant] clears at the same edge.
- Pointer <= grant+1 mod NUM_CH. With no pending bits, the pointer holds and ch_strobe <= 0.

**Simultaneous events:**
- Grant and new due on the same channel in the same cycle: pending stays 1, overrun is not set.
- Due on a channel that is already pending and not granted this cycle: overrun[n] <= 1, and still only one strobe is issued.
- Set and clr_overrun in the same cycle: set wins.

## Timing
- Base tick period is exactly 2^PRESCALE_W clocks. The first base_tick is in the 2nd cycle after reset release.
- Due at base_tick cycle T gives pending visible at T+1 and ch_strobe at T+2 when uncontested.
- With k channels due in the same cycle, strobes occur on k consecutive cycles in round-robin order, earliest at T+2.
- Strobe interval for channel n is period × 2^PRESCALE_W clocks ± (NUM_CH-1) cycles of arbitration jitter. Jitter does not accumulate.
- Reset mid-operation aborts everything immediately. Configuration is lost and must be rewritten.

## Structure
- Package tick_sched_pkg holds:
  - the parameter defaults;
  - typedef ch_idx_t (logic [$clog2(NUM_CH)-1:0]);
  - typedef period_t (logic [PERIOD_W-1:0]);
  - a channel config struct {en, period}.
- Sub-module rr_arbiter:
  - parameter N;
  - inputs: req[N], ptr;
  - outputs: gnt one-hot, gnt_idx, gnt_valid;
  - purely combinational.
- Top-level holds the prescaler, channel counters, pending/overrun registers and the pointer.

## Test plan
All scenarios use PRESCALE_W=4, NUM_CH=4, PERIOD_W=8.
- **Reset/prescaler:** release rst → base_tick at cycle 2, then every 16 cycles; all outputs 0 until the first config write.
- **Single channel:** write ch1 period=3, en=1 → ch_strobe=4'b0010 two cycles after every 3rd base_tick (every 48 cycles); pending/overrun stay clean.
- **Collision/round-robin:** ch0–ch3 all period=1 → strobes on 4 consecutive cycles in order 0,1,2,3; the next tick starts at ch0 again because the pointer wrapped.
- **Overrun:** ch2 period=1 with ch0/ch1/ch3 period=1, and PRESCALE_W overridden to 1 so ticks outpace service → overrun[2]=1, exactly one strobe per service; clr_overrun clears it.
- **Config boundaries:**
  - period=0 or en=0 → no strobe;
  - rewrite ch0 in the same cycle it becomes due → no pending, count reloaded;
  - cfg_ch out of range → no state change.
- **Reset mid-operation:** assert rst with pending=4'b1010 → all outputs 0 asynchronously; no strobes after release until reconfigured.
